hits_bcid_readout: RTL and testbench
====================================

# hits_bcid_readout

Downstream readout stage for the masked hit stream of the bunch-train hit generator. It tracks the bunch-crossing ID (BCID, one per clock) and orbit number, timestamps every incoming hit, and buffers the stamps in a show-ahead FIFO drained over a valid/ready interface. It also publishes per-orbit hit totals and a saturating overflow count for the HPS-side monitor.

## Interface
Parameters:
- BUNCH_POS, 3564, bunch positions per orbit; BCID runs 0..BUNCH_POS-1
- BCID_BITS, 12, BCID field width; must satisfy 2^BCID_BITS >= BUNCH_POS
- ORBIT_BITS, 16, orbit counter width; wraps modulo 2^ORBIT_BITS
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW
- CNT_BITS, 16, width of the hit and overflow counters

Ports:
- clk  in  1  system clock, one bunch crossing per cycle
- rst  in  1  reset; synchronous, active-high
- hit_in  in  1  masked hit for the current bunch crossing (hits_out of the upstream generator)
- out_data  out  OUT_W  FIFO head word (see Configuration for OUT_W)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- fifo_level  out  FIFO_AW+1  words currently stored
- overflow_cnt  out  CNT_BITS  hits dropped because the FIFO was full; saturating
- orbit_hits  out  CNT_BITS  total hits in the last completed orbit, accepted plus dropped
- orbit_tick  out  1  one-cycle pulse when orbit_hits updates

## Operation
- BCID counter:
  - 0 in the first cycle after rst deasserts, which aligns it with the upstream mask position counter.
  - Increments by 1 per cycle. After BUNCH_POS-1 it returns to 0 and the orbit counter increments.
- Hit capture:
  - When hit_in=1, the stamp for the current BCID/orbit is written into the FIFO on that clock edge.
  - Exactly one word is written per hit.
- Pop: a word is popped on any edge where out_valid=1 and out_ready=1.
- Write when full:
  - Full means fifo_level = 2^FIFO_AW, evaluated before the pop of the same cycle.
  - If full and a pop occurs in the same cycle, the write is accepted and the level is unchanged.
  - If full and no pop occurs, the hit is dropped and overflow_cnt increments. overflow_cnt saturates at all-ones.
- Level arithmetic: fifo_level changes by +1 on a write alone, -1 on a pop alone, and 0 when both occur.
- out_data when empty: holds the last popped word (don't-care for the consumer). It must not X-propagate.
- Orbit accumulator:
  - Counts every hit_in=1 (accepted or dropped) within the orbit, saturating at all-ones.
  - On the edge where BCID = BUNCH_POS-1, orbit_hits is loaded with the accumulator value including that cycle's hit. The accumulator restarts from 0.
  - orbit_tick is high for the following cycle.
- Reset mid-operation:
  - The FIFO is emptied and any stored words are discarded.
  - BCID, orbit, accumulator, orbit_hits and overflow_cnt are all cleared.
  - Hits present during rst are ignored.

## Timing
- Reset values: out_valid=0, out_data=0, fifo_level=0, overflow_cnt=0, orbit_hits=0, orbit_tick=0. Internal BCID=0, orbit=0.
- Capture latency: a hit at cycle n into an empty FIFO gives out_valid=1 with its stamp on out_data at cycle n+1.
- Show-ahead: after a pop at cycle n, the next word is on out_data at cycle n+1 with no bubble.
- out_valid is combinational on fifo_level != 0 from registered state only. There is no combinational path from out_ready or hit_in to any output.
- orbit_tick: for the orbit whose last BCID is at cycle n, orbit_tick is high at cycle n+1 and orbit_hits is valid from cycle n+1.

## Configuration
- Macro: HITS_ORBIT_STAMP_EN.
- Defined: OUT_W = ORBIT_BITS + BCID_BITS and out_data = {orbit, bcid}, with the orbit counter implemented.
- Undefined: OUT_W = BCID_BITS and out_data = bcid. The orbit counter is not instantiated. All other behaviour is identical.

## Test plan
- Reset then a single hit at BCID 5, out_ready=1 -> out_valid pulses for 1 cycle at BCID 6 with out_data bcid=5 (orbit=0 with the macro). fifo_level returns to 0.
- hit_in=1 for 20 consecutive cycles, out_ready=0, FIFO_AW=4 -> fifo_level reaches 16; overflow_cnt=4; drained words are bcid 0..15 in order.
- FIFO full with hit_in=1 and out_ready=1 on the same cycle -> write accepted, fifo_level stays 16, overflow_cnt unchanged.
- Hits at BCID 0, 100 and 3563 of orbit 0 -> orbit_tick at the first cycle of orbit 1 with orbit_hits=3. With the macro defined, the next hit stamps orbit=1.
- overflow_cnt preloaded near saturation (CNT_BITS=4, sustained full FIFO) -> overflow_cnt holds at 15.
- rst asserted for 1 cycle with 7 words buffered -> next cycle fifo_level=0, out_valid=0, all counters 0, and BCID restarts at 0.

Source files
------------

// File: rtl/hits_bcid_readout.sv
// Bunch-crossing readout: stamps each hit with BCID (and orbit when HITS_ORBIT_STAMP_EN
// is defined), buffers stamps in a show-ahead FIFO, and keeps per-orbit and overflow counts.
module hits_bcid_readout #(
    parameter int BUNCH_POS  = 3564,
    parameter int BCID_BITS  = 12,
    parameter int ORBIT_BITS = 16,
    parameter int FIFO_AW    = 4,
    parameter int CNT_BITS   = 16,
`ifdef HITS_ORBIT_STAMP_EN
    localparam int OUT_W     = ORBIT_BITS + BCID_BITS
`else
    localparam int OUT_W     = BCID_BITS
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit_in,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FIFO_AW:0]    fifo_level,
    output logic [CNT_BITS-1:0] overflow_cnt,
    output logic [CNT_BITS-1:0] orbit_hits,
    output logic                orbit_tick
);

    localparam logic [FIFO_AW:0]     DEPTH     = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [FIFO_AW:0]     LVL_ONE   = (FIFO_AW+1)'(1);
    localparam logic [BCID_BITS-1:0] BCID_LAST = BCID_BITS'(BUNCH_POS - 1);

    logic [BCID_BITS-1:0] bcid;
    logic [OUT_W-1:0]     stamp;
    logic [OUT_W-1:0]     mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level;
    logic [OUT_W-1:0]     head;
    logic [CNT_BITS-1:0]  acc;
    logic [CNT_BITS-1:0]  acc_next;
    logic [CNT_BITS-1:0]  ovf;
    logic [CNT_BITS-1:0]  hits_q;
    logic                 tick;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 last_bcid;

    // Full is judged before this cycle's pop; a simultaneous pop frees the slot.
    assign full      = (level == DEPTH);
    assign pop       = (level != '0) && out_ready;
    assign push      = hit_in && (!full || pop);
    assign drop      = hit_in && full && !pop;
    assign last_bcid = (bcid == BCID_LAST);
    assign acc_next  = (hit_in && (acc != '1)) ? acc + 1'b1 : acc;

`ifdef HITS_ORBIT_STAMP_EN
    logic [ORBIT_BITS-1:0] orbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            orbit <= '0;
        end else if (last_bcid) begin
            orbit <= orbit + 1'b1;
        end
    end

    assign stamp = {orbit, bcid};
`else
    assign stamp = bcid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bcid <= '0;
        end else if (last_bcid) begin
            bcid <= '0;
        end else begin
            bcid <= bcid + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stamp;
        end
    end

    // The head word lives in its own register so out_data never reads an unwritten slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop && (level > LVL_ONE)) begin
                head <= mem[rd_ptr + 1'b1];
            end else if (push && ((level == '0) || pop)) begin
                head <= stamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf    <= '0;
            acc    <= '0;
            hits_q <= '0;
            tick   <= 1'b0;
        end else begin
            if (drop && (ovf != '1)) begin
                ovf <= ovf + 1'b1;
            end
            tick <= last_bcid;
            if (last_bcid) begin
                hits_q <= acc_next;
                acc    <= '0;
            end else begin
                acc    <= acc_next;
            end
        end
    end

    assign out_data     = head;
    assign out_valid    = (level != '0);
    assign fifo_level   = level;
    assign overflow_cnt = ovf;
    assign orbit_hits   = hits_q;
    assign orbit_tick   = tick;

endmodule

// File: tb/tb_hits_bcid_readout.sv
// Scoreboard bench for hits_bcid_readout: driver pushes expected stamps, a negedge
// monitor pops and compares on every handshake. Honours HITS_ORBIT_STAMP_EN.
module tb_hits_bcid_readout;

  localparam int BUNCH_POS  = 3564;
  localparam int BCID_BITS  = 12;
  localparam int ORBIT_BITS = 16;
  localparam int FIFO_AW    = 4;
  localparam int CNT_BITS   = 4;
  localparam int DEPTH      = 16;
  localparam int CNT_MAX    = 15;
`ifdef HITS_ORBIT_STAMP_EN
  localparam int OUT_W = ORBIT_BITS + BCID_BITS;
`else
  localparam int OUT_W = BCID_BITS;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hit_in = 1'b0;
  logic out_ready = 1'b0;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid;
  logic [FIFO_AW:0]    fifo_level;
  logic [CNT_BITS-1:0] overflow_cnt;
  logic [CNT_BITS-1:0] orbit_hits;
  logic                orbit_tick;

  always #5 clk = ~clk;

  hits_bcid_readout #(
    .BUNCH_POS(BUNCH_POS), .BCID_BITS(BCID_BITS), .ORBIT_BITS(ORBIT_BITS),
    .FIFO_AW(FIFO_AW), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .hit_in(hit_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt),
    .orbit_hits(orbit_hits), .orbit_tick(orbit_tick)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [OUT_W-1:0] exp_q[$];
  int mdl_lvl = 0;
  int mdl_ovf = 0;
  int mdl_bcid = 0;
  int mdl_orbit = 0;

  function automatic logic [OUT_W-1:0] stamp_of(input int b, input int o);
`ifdef HITS_ORBIT_STAMP_EN
    return {ORBIT_BITS'(o), BCID_BITS'(b)};
`else
    return BCID_BITS'(b + 0 * o);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset(input int n, input logic h);
    rst = 1'b1;
    hit_in = h;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    hit_in = 1'b0;
    exp_q.delete();
    mdl_lvl = 0;
    mdl_ovf = 0;
    mdl_bcid = 0;
    mdl_orbit = 0;
  endtask

  task automatic cycle(input logic h, input logic r);
    logic p, f, a, d;
    hit_in = h;
    out_ready = r;
    p = (mdl_lvl != 0) && r;
    f = (mdl_lvl == DEPTH);
    a = h && (!f || p);
    d = h && f && !p;
    @(posedge clk);
    if (a) exp_q.push_back(stamp_of(mdl_bcid, mdl_orbit));
    if (d && mdl_ovf < CNT_MAX) mdl_ovf++;
    mdl_lvl = mdl_lvl + int'(a) - int'(p);
    if (mdl_bcid == BUNCH_POS - 1) begin
      mdl_bcid = 0;
      mdl_orbit = (mdl_orbit + 1) % (1 << ORBIT_BITS);
    end else begin
      mdl_bcid++;
    end
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("fifo_level", 32'(fifo_level), 32'(mdl_lvl));
      check("out_valid", 32'(out_valid), 32'(mdl_lvl != 0));
      check("overflow_cnt", 32'(overflow_cnt), 32'(mdl_ovf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got word 0x%0h, expected no word", out_data);
        end else begin
          check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2, 1'b0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    check("rst_orbit_hits", 32'(orbit_hits), 32'd0);
    check("rst_orbit_tick", 32'(orbit_tick), 32'd0);

    // single hit at BCID 5, consumer always ready
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'(stamp_of(5, 0)));
    cycle(1'b0, 1'b1);
    check("single_valid_after", 32'(out_valid), 32'd0);
    check("single_level_after", 32'(fifo_level), 32'd0);

    // 20 back-to-back hits with no consumer
    do_reset(1, 1'b0);
    repeat (20) cycle(1'b1, 1'b0);
    check("fill_level", 32'(fifo_level), 32'd16);
    check("fill_overflow", 32'(overflow_cnt), 32'd4);
    // full with simultaneous pop: write accepted, level unchanged
    cycle(1'b1, 1'b1);
    check("fullpop_level", 32'(fifo_level), 32'd16);
    check("fullpop_overflow", 32'(overflow_cnt), 32'd4);
    repeat (16) cycle(1'b0, 1'b1);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    // sustained full FIFO drives overflow into saturation
    repeat (30) cycle(1'b1, 1'b0);
    check("sat_overflow", 32'(overflow_cnt), 32'd15);
    repeat (2) cycle(1'b1, 1'b0);
    check("sat_overflow_hold", 32'(overflow_cnt), 32'd15);
    repeat (16) cycle(1'b0, 1'b1);

    // reset with 7 buffered words, hit present during reset
    repeat (7) cycle(1'b1, 1'b0);
    check("pre_rst_level", 32'(fifo_level), 32'd7);
    do_reset(1, 1'b1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow_cnt), 32'd0);
    check("mid_rst_orbit_hits", 32'(orbit_hits), 32'd0);
    check("mid_rst_tick", 32'(orbit_tick), 32'd0);
    // first hit after reset must carry BCID 0
    cycle(1'b1, 1'b1);
    check("restart_data", 32'(out_data), 32'(stamp_of(0, 0)));

    // hits at BCID 0, 100, 3563 of orbit 0
    for (int i = 1; i < BUNCH_POS; i++) begin
      if (i == BUNCH_POS - 1) check("tick_before_end", 32'(orbit_tick), 32'd0);
      cycle((i == 100) || (i == BUNCH_POS - 1), 1'b1);
    end
    check("orbit_tick", 32'(orbit_tick), 32'd1);
    check("orbit_hits", 32'(orbit_hits), 32'd3);
    cycle(1'b1, 1'b1);
    check("orbit1_data", 32'(out_data), 32'(stamp_of(0, 1)));
    check("tick_after", 32'(orbit_tick), 32'd0);
    check("orbit_hits_hold", 32'(orbit_hits), 32'd3);
    repeat (3) cycle(1'b0, 1'b1);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
